// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

    localparam int XLEN = 32;

    // Operation codes presented on the op port; 7 is reserved and acts as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } hl_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } hl_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude for the iterative datapath.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_unit_seq_muldiv.sv
// Iterative unsigned multiply / restoring divide, one bit per step.
// A single 2*XLEN accumulator serves both ops:
//   multiply: {partial product high, multiplier shifting out at bit 0}
//   divide  : {remainder, dividend shifting out / quotient shifting in}
module seq_muldiv
    import hilo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic              i_step,
    output logic              o_last,
    output logic [2*XLEN-1:0] o_acc
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(STEPS - 1);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_is_div;
    logic [CW-1:0]     r_cnt;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_acc_nxt;

    // One step of shift-add (multiply) or shift-subtract (divide).
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        // Remainder shifted left with the next dividend bit appended.
        w_div_sh  = r_acc[2*XLEN-1:XLEN-1];
        w_div_ge  = (w_div_sh >= {1'b0, r_opnd});
        // When w_div_ge holds the difference is below the divisor, so it fits XLEN bits.
        w_div_sub = w_div_sh[XLEN-1:0] - r_opnd;
        if (r_is_div) begin
            if (w_div_ge)
                w_acc_nxt = {w_div_sub, r_acc[XLEN-2:0], 1'b1};
            else
                w_acc_nxt = {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    // Load operands on start, advance accumulator and counter on each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_is_div <= i_is_div;
            r_cnt    <= CNT_INIT;
            if (i_is_div) begin
                r_acc  <= {{XLEN{1'b0}}, i_a};
                r_opnd <= i_b;
            end else begin
                r_acc  <= {{XLEN{1'b0}}, i_b};
                r_opnd <= i_a;
            end
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == '0);
    assign o_acc  = r_acc;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Control FSM, sign handling, divide-by-zero override and cancel live here;
// the bit-serial datapath lives in seq_muldiv.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    hl_state_t         r_state, w_state_nxt;
    hl_op_t            w_op;

    logic [XLEN-1:0]   r_hi, r_lo;
    logic              r_busy, r_done;
    logic              r_is_div, r_neg_q, r_neg_r, r_dz;
    logic [XLEN-1:0]   r_a_raw;

    logic              w_is_mul, w_is_div, w_signed, w_accept;
    logic              w_start, w_step, w_write, w_mthi, w_mtlo;
    logic              w_last;
    logic [XLEN-1:0]   w_opa, w_opb;
    logic [2*XLEN-1:0] w_acc, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

    assign w_op     = hl_op_t'(op);
    assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_accept = (r_state == ST_IDLE) && op_valid && !cancel;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; cancel drops any in-flight op straight back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_state_nxt = ST_CALC;
            ST_CALC: if (cancel) w_state_nxt = ST_IDLE;
                     else if (w_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        w_start = 1'b0;
        w_step  = 1'b0;
        w_write = 1'b0;
        w_mthi  = 1'b0;
        w_mtlo  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_accept && (w_is_mul || w_is_div);
                w_mthi  = w_accept && (w_op == OP_MTHI);
                w_mtlo  = w_accept && (w_op == OP_MTLO);
            end
            ST_CALC: w_step  = !cancel;
            ST_FIX:  w_write = !cancel;
            default: ;
        endcase
    end

    // Signed ops feed magnitudes to the unsigned datapath.
    assign w_opa = w_signed ? mag(a) : a;
    assign w_opb = w_signed ? mag(b) : b;

    seq_muldiv #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_is_div (w_is_div),
        .i_a      (w_opa),
        .i_b      (w_opb),
        .i_step   (w_step),
        .o_last   (w_last),
        .o_acc    (w_acc)
    );

    // Latch op kind, sign flags and divide-by-zero info at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_a_raw  <= '0;
        end else if (w_start) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_r  <= w_signed && a[XLEN-1];
            r_dz     <= (b == '0);
            r_a_raw  <= a;
        end
    end

    // Sign correction and divide-by-zero override applied during FIX.
    always_comb begin
        w_prod = r_neg_q ? (~w_acc + 1'b1) : w_acc;
        w_quo  = r_neg_q ? (~w_acc[XLEN-1:0] + 1'b1) : w_acc[XLEN-1:0];
        w_rem  = r_neg_r ? (~w_acc[2*XLEN-1:XLEN] + 1'b1) : w_acc[2*XLEN-1:XLEN];
        if (!r_is_div) begin
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end else if (r_dz) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    // HI/LO registers: MT writes at acceptance, MULT/DIV results at end of FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_write) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    // Registered busy/done so downstream stall logic sees clean flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_write;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
